// File: rtl/led_drv_pkg.sv
// Shared definitions for the MiniLED zone sender.
//   ZONE_W  : zone index width (up to 512 zones)
//   LIGHT_W : per-zone brightness width
//   OVR_W   : overrun counter width
//   RAM_AW  : zone RAM address width ({bank, idx})
//   state_e : sender FSM states
//   sat_inc : saturating increment for the overrun counter
package led_drv_pkg;

  localparam int unsigned ZONE_W  = 9;
  localparam int unsigned LIGHT_W = 16;
  localparam int unsigned OVR_W   = 8;
  localparam int unsigned RAM_AW  = ZONE_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCapture,
    StShift,
    StNext,
    StLatch,
    StDone
  } state_e;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/zone_ram_dp.sv
// Simple dual-port zone RAM holding both frame banks (address = {bank, idx}).
// Ports:
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address, sampled every cycle
//   rdata_o : registered read data, one cycle after raddr_i
// Contents are not reset.
module zone_ram_dp
  import led_drv_pkg::*;
(
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [RAM_AW-1:0]  waddr_i,
  input  logic [LIGHT_W-1:0] wdata_i,
  input  logic [RAM_AW-1:0]  raddr_i,
  output logic [LIGHT_W-1:0] rdata_o
);

  logic [LIGHT_W-1:0] mem_q [2**RAM_AW];
  logic [LIGHT_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/led_zone_sender.sv
// MiniLED zone sender: collects indexed per-zone brightness values into a
// double-buffered zone RAM and shifts each completed frame MSB-first to the
// daisy-chained driver ICs over sclk/sdo, followed by a lat pulse.
// Zone ZONES-1 is shifted first so zone 0 ends up in the nearest device.
// Ports:
//   sys_clk     : clock, rising edge
//   sys_rst     : asynchronous active-low reset
//   light_in    : zone brightness value
//   light_idx   : zone index of light_in (ignored when >= ZONES)
//   light_wr    : write strobe
//   frame_done  : one-cycle end-of-frame pulse
//   test_en     : (LED_TEST_PATTERN_EN only) send {7'b0, zone} instead of RAM data
//   sclk        : serial clock to the driver chain
//   sdo         : serial data, changes only while sclk is low
//   lat         : latch pulse after the last bit
//   busy        : high for the whole send
//   overrun_cnt : saturating count of frames replaced before being sent
// Optional feature macro: LED_TEST_PATTERN_EN.
module led_zone_sender
  import led_drv_pkg::*;
#(
  parameter int unsigned ZONES     = 384,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned LAT_WIDTH = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [LIGHT_W-1:0] light_in,
  input  logic [ZONE_W-1:0]  light_idx,
  input  logic               light_wr,
  input  logic               frame_done,
`ifdef LED_TEST_PATTERN_EN
  input  logic               test_en,
`endif
  output logic               sclk,
  output logic               sdo,
  output logic               lat,
  output logic               busy,
  output logic [OVR_W-1:0]   overrun_cnt
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LatW = (LAT_WIDTH > 1) ? $clog2(LAT_WIDTH) : 1;
  localparam logic [DivW-1:0]   DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [LatW-1:0]   LatLast  = LatW'(LAT_WIDTH - 1);
  localparam logic [ZONE_W-1:0] ZoneLast = ZONE_W'(ZONES - 1);

  state_e              state_q, state_d;
  logic [ZONE_W-1:0]   z_q, z_d;
  logic [3:0]          bit_q, bit_d;
  logic [DivW-1:0]     div_q, div_d;
  logic                phase_q, phase_d;
  logic [LatW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [LIGHT_W-1:0]  shift_q, shift_d;
  logic                wr_bank_q, wr_bank_d;
  logic                pending_q, pending_d;
  logic [OVR_W-1:0]    ovr_q, ovr_d;
  logic                sclk_q, sclk_d;
  logic                sdo_q, sdo_d;
  logic                lat_q, lat_d;
  logic                busy_q, busy_d;
  logic                start;
  logic                ram_we;
  logic [LIGHT_W-1:0]  rd_data;
  logic [LIGHT_W-1:0]  load_word;

  // Writes always target wr_bank; the sender reads the other bank.
  assign ram_we = light_wr && (32'(light_idx) < ZONES);

  zone_ram_dp u_ram (
    .clk_i   (sys_clk),
    .we_i    (ram_we),
    .waddr_i ({wr_bank_q, light_idx}),
    .wdata_i (light_in),
    .raddr_i ({~wr_bank_q, z_q}),
    .rdata_o (rd_data)
  );

`ifdef LED_TEST_PATTERN_EN
  logic test_q, test_d;
  assign load_word = test_q ? {7'b0, z_q} : rd_data;
`else
  assign load_word = rd_data;
`endif

  always_comb begin
    state_d   = state_q;
    z_d       = z_q;
    bit_d     = bit_q;
    div_d     = div_q;
    phase_d   = phase_q;
    lat_cnt_d = lat_cnt_q;
    shift_d   = shift_q;
    wr_bank_d = wr_bank_q;
    pending_d = pending_q;
    ovr_d     = ovr_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;
    lat_d     = lat_q;
    busy_d    = busy_q;
    start     = 1'b0;
`ifdef LED_TEST_PATTERN_EN
    test_d    = test_q;
`endif

    // A frame closing mid-send is parked; a second one overwrites the parked bank.
    if (frame_done && (state_q != StIdle) && (state_q != StDone)) begin
      if (pending_q) begin
        ovr_d = sat_inc(ovr_q);
      end else begin
        pending_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (frame_done) begin
          start = 1'b1;
        end
      end
      StLoad: begin
        state_d = StCapture;
      end
      StCapture: begin
        state_d = StShift;
        shift_d = load_word;
        sdo_d   = load_word[LIGHT_W-1];
        bit_d   = 4'd15;
        div_d   = '0;
        phase_d = 1'b0;
        sclk_d  = 1'b0;
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_q == 4'd0) begin
              state_d = StNext;
            end else begin
              // Next bit goes out together with the falling sclk edge.
              bit_d   = bit_q - 4'd1;
              shift_d = {shift_q[LIGHT_W-2:0], 1'b0};
              sdo_d   = shift_q[LIGHT_W-2];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StNext: begin
        if (z_q == '0) begin
          state_d   = StLatch;
          lat_d     = 1'b1;
          sdo_d     = 1'b0;
          lat_cnt_d = '0;
        end else begin
          z_d     = z_q - 1'b1;
          state_d = StLoad;
        end
      end
      StLatch: begin
        if (lat_cnt_q == LatLast) begin
          state_d = StDone;
          lat_d   = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (pending_q) begin
          start     = 1'b1;
          pending_d = 1'b0;
          if (frame_done) begin
            ovr_d = sat_inc(ovr_q);
          end
        end else if (frame_done) begin
          start = 1'b1;
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (start) begin
      state_d   = StLoad;
      busy_d    = 1'b1;
      wr_bank_d = ~wr_bank_q;
      z_d       = ZoneLast;
`ifdef LED_TEST_PATTERN_EN
      test_d    = test_en;
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= StIdle;
      z_q       <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      phase_q   <= 1'b0;
      lat_cnt_q <= '0;
      shift_q   <= '0;
      wr_bank_q <= 1'b0;
      pending_q <= 1'b0;
      ovr_q     <= '0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      lat_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef LED_TEST_PATTERN_EN
      test_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      z_q       <= z_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      lat_cnt_q <= lat_cnt_d;
      shift_q   <= shift_d;
      wr_bank_q <= wr_bank_d;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      lat_q     <= lat_d;
      busy_q    <= busy_d;
`ifdef LED_TEST_PATTERN_EN
      test_q    <= test_d;
`endif
    end
  end

  assign sclk        = sclk_q;
  assign sdo         = sdo_q;
  assign lat         = lat_q;
  assign busy        = busy_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_led_zone_sender.sv
// Bench for led_zone_sender with ZONES=4, CLK_DIV=1, LAT_WIDTH=4.
module tb_led_zone_sender;
  localparam int unsigned ZONES     = 4;
  localparam int unsigned CLK_DIV   = 1;
  localparam int unsigned LAT_WIDTH = 4;
  localparam int unsigned FRAME_CYC = ZONES * (3 + 32 * CLK_DIV) + LAT_WIDTH + 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [15:0] light_in = '0;
  logic [8:0]  light_idx = '0;
  logic        light_wr = 1'b0;
  logic        frame_done = 1'b0;
`ifdef LED_TEST_PATTERN_EN
  logic        test_en = 1'b0;
`endif
  logic        sclk, sdo, lat, busy;
  logic [7:0]  overrun_cnt;

  led_zone_sender #(
    .ZONES     (ZONES),
    .CLK_DIV   (CLK_DIV),
    .LAT_WIDTH (LAT_WIDTH)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .light_in    (light_in),
    .light_idx   (light_idx),
    .light_wr    (light_wr),
    .frame_done  (frame_done),
`ifdef LED_TEST_PATTERN_EN
    .test_en     (test_en),
`endif
    .sclk        (sclk),
    .sdo         (sdo),
    .lat         (lat),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  initial forever #5 sys_clk = ~sys_clk;

  // Serial monitor: samples on the falling sys_clk edge, away from updates.
  logic [15:0] words[$];
  logic [15:0] acc = '0;
  int          nbits = 0;
  int          rises = 0;
  int          busy_cycles = 0;
  int          lat_cycles = 0;
  int          busy_rises = 0;
  logic        sclk_prev = 1'b0;
  logic        busy_prev = 1'b0;

  initial forever begin
    @(negedge sys_clk);
    if (!sys_rst) begin
      acc = '0;
      nbits = 0;
      sclk_prev = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (sclk && !sclk_prev) begin
        acc = {acc[14:0], sdo};
        nbits++;
        rises++;
        if (nbits == 16) begin
          words.push_back(acc);
          nbits = 0;
        end
      end
      if (busy) busy_cycles++;
      if (lat) lat_cycles++;
      if (busy && !busy_prev) busy_rises++;
      sclk_prev = sclk;
      busy_prev = busy;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_zone(input logic [8:0] idx, input logic [15:0] val);
    light_idx = idx;
    light_in  = val;
    light_wr  = 1'b1;
    tick();
    light_wr  = 1'b0;
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic check_words(input string tag, input int base, input logic [3:0][15:0] exp);
    for (int k = 0; k < 4; k++) begin
      if (base + k < words.size()) begin
        check($sformatf("%s_word%0d", tag, k), 32'(words[base + k]), 32'(exp[k]));
      end else begin
        check($sformatf("%s_word%0d_missing", tag, k), 32'(words.size()), 32'(base + k + 1));
      end
    end
  endtask

  typedef struct packed {
    logic [3:0][8:0]  idx;
    logic [3:0][15:0] data;
    logic [3:0][15:0] exp;   // exp[0] is the first word shifted out
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bw, bb, bl, br, bbr;

    // Banks alternate 0,1,0,1; vector 2 leaves zones 0/1 stale from vector 0.
    vecs[0].idx  = {9'd3, 9'd2, 9'd1, 9'd0};
    vecs[0].data = {16'hFFFF, 16'h8000, 16'h0001, 16'hA5A5};
    vecs[0].exp  = {16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF};
    vecs[1].idx  = {9'd3, 9'd2, 9'd1, 9'd0};
    vecs[1].data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    vecs[1].exp  = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    vecs[2].idx  = {9'd4, 9'd400, 9'd2, 9'd3};
    vecs[2].data = {16'hBEEF, 16'hDEAD, 16'h7777, 16'h0F0F};
    vecs[2].exp  = {16'hA5A5, 16'h0001, 16'h7777, 16'h0F0F};
    vecs[3].idx  = {9'd3, 9'd2, 9'd1, 9'd0};
    vecs[3].data = {16'h8001, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[3].exp  = {16'h0000, 16'hFFFF, 16'h0000, 16'h8001};

    // Reset state.
    repeat (3) tick();
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_lat", 32'(lat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    sys_rst = 1'b1;
    repeat (2) tick();

    // Table-driven frames.
    for (int v = 0; v < 4; v++) begin
      bw = words.size(); bb = busy_cycles; bl = lat_cycles; br = rises;
      for (int k = 0; k < 4; k++) write_zone(vecs[v].idx[k], vecs[v].data[k]);
      pulse_done();
      check($sformatf("v%0d_busy_start", v), 32'(busy), 32'd1);
      wait_idle($sformatf("v%0d", v));
      check($sformatf("v%0d_nwords", v), 32'(words.size() - bw), 32'd4);
      check_words($sformatf("v%0d", v), bw, vecs[v].exp);
      check($sformatf("v%0d_busy_cycles", v), 32'(busy_cycles - bb), 32'(FRAME_CYC));
      check($sformatf("v%0d_lat_cycles", v), 32'(lat_cycles - bl), 32'(LAT_WIDTH));
      check($sformatf("v%0d_sclk_rises", v), 32'(rises - br), 32'd64);
      check($sformatf("v%0d_overrun", v), 32'(overrun_cnt), 32'd0);
      repeat (2) tick();
    end

    // Write coinciding with frame_done belongs to the closing frame; start latency.
    bw = words.size();
    write_zone(9'd0, 16'h0101);
    write_zone(9'd1, 16'h0202);
    write_zone(9'd3, 16'h8404);
    light_idx = 9'd2; light_in = 16'h1234; light_wr = 1'b1; frame_done = 1'b1;
    tick();
    light_wr = 1'b0; frame_done = 1'b0;
    check("lat_busy_t1", 32'(busy), 32'd1);
    tick();
    tick();
    check("lat_sclk_t3", 32'(sclk), 32'd0);
    check("lat_sdo_t3", 32'(sdo), 32'd1);
    tick();
    check("lat_sclk_t4", 32'(sclk), 32'd1);
    wait_idle("same");
    check_words("same", bw, {16'h0101, 16'h0202, 16'h1234, 16'h8404});
    repeat (2) tick();

    // Three frame_done pulses during one send: back-to-back, latest frame wins.
    bw = words.size(); bb = busy_cycles; bbr = busy_rises;
    write_zone(9'd0, 16'hC000); write_zone(9'd1, 16'hC001);
    write_zone(9'd2, 16'hC002); write_zone(9'd3, 16'hC003);
    pulse_done();
    repeat (10) tick();
    write_zone(9'd0, 16'hD000); write_zone(9'd1, 16'hD001);
    write_zone(9'd2, 16'hD002); write_zone(9'd3, 16'hD003);
    pulse_done();
    check("ovr_after_pending", 32'(overrun_cnt), 32'd0);
    write_zone(9'd0, 16'hE000); write_zone(9'd1, 16'hE001);
    write_zone(9'd2, 16'hE002); write_zone(9'd3, 16'hE003);
    pulse_done();
    check("ovr_after_third", 32'(overrun_cnt), 32'd1);
    wait_idle("b2b");
    check("b2b_nwords", 32'(words.size() - bw), 32'd8);
    check_words("b2b_f1", bw, {16'hC000, 16'hC001, 16'hC002, 16'hC003});
    check_words("b2b_f2", bw + 4, {16'hE000, 16'hE001, 16'hE002, 16'hE003});
    check("b2b_busy_rises", 32'(busy_rises - bbr), 32'd1);
    check("b2b_busy_cycles", 32'(busy_cycles - bb), 32'(2 * FRAME_CYC));
    check("b2b_overrun_end", 32'(overrun_cnt), 32'd1);
    repeat (2) tick();

    // Asynchronous reset mid-SHIFT with sclk and sdo high.
    write_zone(9'd0, 16'h1000); write_zone(9'd1, 16'h2000);
    write_zone(9'd2, 16'h3000); write_zone(9'd3, 16'hFFFF);
    pulse_done();
    begin
      int n = 0;
      while (!sclk && n < 50) begin
        tick();
        n++;
      end
    end
    check("mid_sclk_high", 32'(sclk), 32'd1);
    check("mid_sdo_high", 32'(sdo), 32'd1);
    #2 sys_rst = 1'b0;
    #1;
    check("arst_sclk", 32'(sclk), 32'd0);
    check("arst_sdo", 32'(sdo), 32'd0);
    check("arst_lat", 32'(lat), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_overrun", 32'(overrun_cnt), 32'd0);
    repeat (2) tick();
    sys_rst = 1'b1;
    tick();
    bw = words.size(); bb = busy_cycles;
    write_zone(9'd0, 16'h0F00); write_zone(9'd1, 16'h00F0);
    write_zone(9'd2, 16'h000F); write_zone(9'd3, 16'hF000);
    pulse_done();
    wait_idle("post_rst");
    check("post_rst_nwords", 32'(words.size() - bw), 32'd4);
    check_words("post_rst", bw, {16'h0F00, 16'h00F0, 16'h000F, 16'hF000});
    check("post_rst_busy_cycles", 32'(busy_cycles - bb), 32'(FRAME_CYC));

`ifdef LED_TEST_PATTERN_EN
    // Test pattern: test_en sampled at start, dropped right after.
    repeat (2) tick();
    bw = words.size();
    test_en = 1'b1;
    pulse_done();
    test_en = 1'b0;
    wait_idle("tpat");
    check("tpat_nwords", 32'(words.size() - bw), 32'd4);
    check_words("tpat", bw, {16'h0000, 16'h0001, 16'h0002, 16'h0003});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
